// File: rtl/chacha_block_port.sv
// ChaCha block port: loads key/counter/nonce bytes into the quarter-round
// array, kicks the round sequencer and streams the 64 keystream bytes out.
module chacha_block_port #(
  parameter logic [5:0] LOAD_BASE = 6'd16,
  parameter logic [5:0] LOAD_END  = 6'd63
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_req,
  input  logic       gen_req,
  output logic       busy,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [5:0] bus_addr,
  output logic [7:0] bus_wdata,
  output logic       bus_write,
  input  logic [7:0] bus_rdata,
  output logic       core_start,
  input  logic       core_done,
  output logic       inc_ctr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_WAIT,
    S_DRAIN,
    S_INC
  } state_t;

  state_t     state, state_d;
  logic [5:0] addr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      bus_addr <= 6'd0;
    end else begin
      state    <= state_d;
      bus_addr <= addr_d;
    end
  end

  always_comb begin
    state_d    = state;
    addr_d     = bus_addr;
    in_ready   = 1'b0;
    bus_write  = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    core_start = 1'b0;
    inc_ctr    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (load_req) begin
          state_d = S_LOAD;
          addr_d  = LOAD_BASE;
        end else if (gen_req) begin
          state_d = S_START;
        end
      end
      S_LOAD: begin
        in_ready  = 1'b1;
        bus_write = in_valid;
        if (in_valid) begin
          if (bus_addr == LOAD_END) begin
            state_d = S_IDLE;
            addr_d  = 6'd0;
          end else begin
            addr_d = bus_addr + 6'd1;
          end
        end
      end
      S_START: begin
        core_start = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (core_done) begin
          state_d = S_DRAIN;
          addr_d  = 6'd0;
        end
      end
      S_DRAIN: begin
        out_valid = 1'b1;
        out_last  = (bus_addr == 6'd63);
        if (out_ready) begin
          if (bus_addr == 6'd63) begin
            state_d = S_INC;
            addr_d  = 6'd0;
          end else begin
            addr_d = bus_addr + 6'd1;
          end
        end
      end
      S_INC: begin
        inc_ctr = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        addr_d  = 6'd0;
      end
    endcase
  end

  // Data paths are gated so idle and reset leave every output at zero.
  assign busy      = (state != S_IDLE);
  assign bus_wdata = in_ready ? in_data : 8'd0;
  assign out_data  = out_valid ? bus_rdata : 8'd0;

endmodule

// File: doc/chacha_block_port.md
Name: chacha_block_port

Overview:
- Host-facing master for the byte-addressed block bus of the ChaCha quarter-round array.
- Loads 48 bytes of key/counter/nonce from a valid/ready byte stream into array rows 1–3.
- On request, triggers the round sequencer, then reads the 64 keystream bytes back out as a valid/ready stream.
- After each block, pulses the block-counter increment.

Parameters:
- LOAD_BASE, 6'd16: first byte address written during load (row 1, col 0, byte 0).
- LOAD_END, 6'd63: last byte address written during load.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- load_req  in  1  pulse: begin 48-byte load
- gen_req  in  1  pulse: generate and stream one keystream block
- busy  out  1  high in any state except IDLE
- in_valid  in  1  host load byte valid
- in_ready  out  1  accepting load byte
- in_data  in  8  load byte
- out_valid  out  1  keystream byte valid
- out_ready  in  1  downstream accepts byte
- out_data  out  8  keystream byte
- out_last  out  1  high with byte at address 63
- bus_addr  out  6  array byte address {row[1:0], col[1:0], byte[1:0]}
- bus_wdata  out  8  array write data
- bus_write  out  1  array write strobe
- bus_rdata  in  8  OR of all quarter data_out buses (combinational from bus_addr)
- core_start  out  1  pulse to round sequencer: clear, 20 rounds, add_back
- core_done  in  1  pulse from sequencer: block result valid in array
- inc_ctr  out  1  pulse: increment block counter

Behaviour:
- Reset (async, rst_n low), all outputs 0: state=IDLE, bus_addr=0, busy=0, in_ready=0, out_valid=0, out_last=0, bus_write=0, core_start=0, inc_ctr=0.
- Reset mid-operation aborts immediately. Partially written init words keep their bytes; the array is not cleared by this block.
- States: IDLE, LOAD, START, WAIT, DRAIN, INC.
- IDLE:
  - load_req → LOAD, bus_addr←LOAD_BASE.
  - else gen_req → START.
  - load_req wins if both are high.
  - Requests in any other state are ignored (not queued).
- LOAD:
  - in_ready=1.
  - bus_write = in_valid, combinational; bus_wdata = in_data.
  - On in_valid&&in_ready, the byte is written at the current bus_addr that cycle.
  - If bus_addr==LOAD_END → IDLE, bus_addr←0; else bus_addr←bus_addr+1.
  - in_valid low holds the address, with no write.
- START: core_start=1 for exactly one cycle → WAIT.
- WAIT:
  - bus_write=0.
  - Wait for core_done, unbounded.
  - On core_done → DRAIN, bus_addr←0.
  - core_done outside WAIT is ignored.
- DRAIN:
  - out_valid=1; out_data=bus_rdata; out_last=(bus_addr==63).
  - On out_ready:
    - if bus_addr==63 → INC, bus_addr←0;
    - else bus_addr+1.
  - Byte order is address order: row0 col0 byte0 first, row3 col3 byte3 last (little-endian words, row-major).
  - out_ready low holds bus_addr, so out_data stays stable.
- INC: inc_ctr=1 for exactly one cycle → IDLE.
- Address arithmetic is 6-bit. The increment past 63 never occurs: it is guarded by the state transitions.
- bus_write is asserted only in LOAD, and never in the same cycle as core_start or inc_ctr.
- Throughput: 1 byte/cycle in LOAD and DRAIN with continuous handshakes. A full block is 1 (START) + sequencer latency + 64 + 1 cycles.

Test Plan:
- Reset: rst_n low asynchronously mid-DRAIN at address 20 → in the same cycle out_valid=0, busy=0, bus_addr=0. After release, state IDLE.
- Load: load_req, then 48 bytes 0x00..0x2F with in_valid held → writes at addresses 16..63 with wdata=addr−16. in_ready drops and busy=0 after 48 accepted bytes.
- Load with gaps: in_valid toggled every other cycle → still exactly 48 writes, no repeated or skipped address. gen_req asserted during LOAD is ignored.
- Generate: gen_req; model drives core_done 10 cycles after core_start → one core_start pulse, then 64 bytes equal to model array contents at addresses 0..63. out_last only on the 64th byte, then one inc_ctr pulse, then busy=0.
- Backpressure: out_ready random 50% during DRAIN → out_data held stable while out_ready low. Exactly 64 transfers, order preserved.
- Simultaneous: load_req and gen_req asserted in the same IDLE cycle → LOAD taken, no core_start. A stray core_done in IDLE → no state change.
